mesm6_mem_arbiter: RTL and testbench
====================================

# mesm6_mem_arbiter

Single-port memory arbiter sharing one 48-bit word memory between the MESM-6 core's instruction bus and data bus. It sits between `mesm6_core` and the unified memory. It serializes simultaneous fetch and data requests and returns all `*_done` strobes in one joint completion cycle, so the core's stall logic releases exactly once per microinstruction. An optional third port gives a DMA/peripheral master access to the memory.

## Interface
- `DATA_FIRST`, default 1: when both CPU buses request together, 1 serves the data bus first and 0 serves the instruction bus first.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ibus_fetch`  in  1  instruction fetch request (level; held until `ibus_done`).
- `ibus_addr`  in  15  fetch word address.
- `ibus_input`  out  48  fetched word (registered).
- `ibus_done`  out  1  fetch complete (one-cycle pulse).
- `dbus_read`, `dbus_write`  in  1  data read/write request (level; held until `dbus_done`; never both high).
- `dbus_addr`  in  15  data word address.
- `dbus_output`  in  48  write data from core.
- `dbus_input`  out  48  read data (registered).
- `dbus_done`  out  1  data op complete (one-cycle pulse).
- `mem_read`, `mem_write`  out  1  memory strobes (held until `mem_done`).
- `mem_addr`  out  15  memory address.
- `mem_wdata`  out  48  memory write data.
- `mem_rdata`  in  48  memory read data, valid in the `mem_done` cycle.
- `mem_done`  in  1  memory completion pulse; may arrive in the first strobe cycle.
- DMA ports, present only with the macro: `dma_req`, `dma_we` in 1; `dma_addr` in 15; `dma_wdata` in 48; `dma_rdata` out 48; `dma_ack` out 1 (one-cycle pulse).

## Operation
- FSM states: IDLE, ACC_D, ACC_I, ACC_DMA, DONE.
- **IDLE**
  - Sample the CPU requests into a pending mask {i,d}.
  - If the mask is nonzero, go to the first access per `DATA_FIRST`.
  - Otherwise, with `dma_req`, go to ACC_DMA.
  - Otherwise stay in IDLE.
- **ACC_D**
  - Drive `mem_read` or `mem_write` with `dbus_addr`/`dbus_output`.
  - On `mem_done`: capture `mem_rdata` into the dbus data register if the op is a read, and clear d in the mask.
  - Next state is ACC_I if i is still pending, else DONE.
- **ACC_I**
  - Drive `mem_read` with `ibus_addr`.
  - On `mem_done`: capture into the ibus data register and clear i.
  - Next state is ACC_D if d is still pending, else DONE.
- **DONE**
  - Pulse `ibus_done` and/or `dbus_done` for the requesters served in this round. Pulse both together when both were served.
  - Next state: IDLE.
- **ACC_DMA**
  - Drive the strobe from `dma_we`.
  - On `mem_done`: pulse `dma_ack` in the next cycle, latch `dma_rdata`, return to IDLE.
- The pending mask is frozen at the IDLE sample. A request that rises mid-round waits for the next round.
- Exactly one memory strobe is high at any time.
- `mem_addr` and `mem_wdata` are stable while a strobe is high.
- `ibus_input`/`dbus_input` hold their last captured value until the next capture.
- Reset values:
  - state IDLE, mask 0;
  - all strobes, `*_done` and `dma_ack` low;
  - data registers 0.

## Timing
- Single CPU request with zero-wait memory: request seen in IDLE (cycle 0), access in cycle 1, `*_done` in cycle 2. Latency is 2 cycles plus memory wait states.
- Dual request: both `done`s pulse in cycle 3 plus wait states.
- The cycle after DONE is always IDLE. The core's next microinstruction is sampled there, so a held request is never served twice.
- DMA can start only from IDLE with no CPU request. A CPU request arriving during ACC_DMA waits at most one DMA access plus one cycle.
- `mem_done` outside a strobe is ignored.
- Reset asserted mid-access:
  - strobes drop the next cycle and no `done` is issued;
  - the memory controller is reset by the same signal.

## Configuration
- `MESM6_ARB_DMA_EN` defined: DMA ports and the ACC_DMA state exist. The DMA port has the lowest priority and is served only in idle cycles.
- Not defined: DMA ports are absent, ACC_DMA is unreachable and removed, and the FSM has four states.

## Structure
- Package `mesm6_arb_pkg` holds:
  - the state enum `arb_state_t`;
  - `MEM_AW` = 15 and `MEM_DW` = 48;
  - the pending-mask bit indices.
- Single module; no sub-module needed.
- The strobe/address mux is a combinational decode of the state inside the module.

## Test plan
- **Lone fetch:** `ibus_fetch`, addr 0o100, memory returns 0x123456789ABC with 0 wait → `mem_read` high cycle 1, `ibus_done` pulse cycle 2, `ibus_input` = 0x123456789ABC, `dbus_done` stays low.
- **Simultaneous fetch + read, `DATA_FIRST`=1:** order on `mem_addr` is dbus then ibus; both `done`s pulse in the same single cycle (cycle 3); each data register holds its own word.
- **Write with 3 wait states:** `dbus_write`, addr 5, data 0xFFFF00000001 → `mem_write` held 4 cycles with constant addr/data, then one `dbus_done` pulse; no second access while the request is still high in the DONE cycle.
- **Back-to-back:** fetch held continuously across two microinstructions → exactly two memory reads, separated by DONE and IDLE cycles.
- **Reset mid-access:** `reset` during ACC_I with no `mem_done` → next cycle strobes low, no `done` pulse, state IDLE.
- **DMA (macro on):** `dma_req` while the CPU is idle → ACC_DMA, `dma_ack` pulse; a CPU fetch raised during it is served right after, with fetch latency ≤ DMA latency + 3 cycles.

Source files
------------

// File: rtl/mesm6_arb_pkg.sv
// rtl/mesm6_arb_pkg.sv - shared types for the MESM-6 memory arbiter; MESM6_ARB_DMA_EN adds the DMA state
package mesm6_arb_pkg;

  localparam int MEM_AW = 15;
  localparam int MEM_DW = 48;

  localparam int PEND_D = 0;
  localparam int PEND_I = 1;
  localparam int PEND_W = 2;

`ifdef MESM6_ARB_DMA_EN
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ACC_D,
    ARB_ACC_I,
    ARB_DONE,
    ARB_ACC_DMA
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACC_D,
    ARB_ACC_I,
    ARB_DONE
  } arb_state_t;
`endif

  // First access of a round; the data bus wins ties only when data_first is set.
  function automatic arb_state_t first_access(input logic [PEND_W-1:0] mask, input bit data_first);
    if (mask[PEND_D] && (data_first || !mask[PEND_I]))
      return ARB_ACC_D;
    else if (mask[PEND_I])
      return ARB_ACC_I;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mesm6_mem_arbiter.sv
// rtl/mesm6_mem_arbiter.sv - single-port memory arbiter for the MESM-6 instruction/data buses
// MESM6_ARB_DMA_EN adds a lowest-priority DMA master port.
module mesm6_mem_arbiter
  import mesm6_arb_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ibus_fetch,
  input  logic [MEM_AW-1:0] ibus_addr,
  output logic [MEM_DW-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [MEM_AW-1:0] dbus_addr,
  input  logic [MEM_DW-1:0] dbus_output,
  output logic [MEM_DW-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata,
  input  logic              mem_done
`ifdef MESM6_ARB_DMA_EN
 ,input  logic              dma_req,
  input  logic              dma_we,
  input  logic [MEM_AW-1:0] dma_addr,
  input  logic [MEM_DW-1:0] dma_wdata,
  output logic [MEM_DW-1:0] dma_rdata,
  output logic              dma_ack
`endif
);

  arb_state_t        state, state_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic [PEND_W-1:0] served, served_nxt;
  logic              d_we, d_we_nxt;
  logic              ibus_cap, dbus_cap;
  logic [PEND_W-1:0] req;
`ifdef MESM6_ARB_DMA_EN
  logic              dma_cap;
`endif

  always_comb begin
    req         = '0;
    req[PEND_I] = ibus_fetch;
    req[PEND_D] = dbus_read | dbus_write;
  end

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    served_nxt = served;
    d_we_nxt   = d_we;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ibus_done  = 1'b0;
    dbus_done  = 1'b0;
    ibus_cap   = 1'b0;
    dbus_cap   = 1'b0;
`ifdef MESM6_ARB_DMA_EN
    dma_cap    = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        // The round's mask is frozen here; later requests wait for the next round.
        pend_nxt   = req;
        served_nxt = req;
        d_we_nxt   = dbus_write;
        if (|req)
          state_nxt = first_access(req, DATA_FIRST);
`ifdef MESM6_ARB_DMA_EN
        else if (dma_req)
          state_nxt = ARB_ACC_DMA;
`endif
      end
      ARB_ACC_D: begin
        mem_read  = ~d_we;
        mem_write = d_we;
        mem_addr  = dbus_addr;
        mem_wdata = dbus_output;
        if (mem_done) begin
          dbus_cap         = ~d_we;
          pend_nxt[PEND_D] = 1'b0;
          state_nxt        = pend[PEND_I] ? ARB_ACC_I : ARB_DONE;
        end
      end
      ARB_ACC_I: begin
        mem_read = 1'b1;
        mem_addr = ibus_addr;
        if (mem_done) begin
          ibus_cap         = 1'b1;
          pend_nxt[PEND_I] = 1'b0;
          state_nxt        = pend[PEND_D] ? ARB_ACC_D : ARB_DONE;
        end
      end
      ARB_DONE: begin
        // One joint completion so the core's stall releases once per microinstruction.
        ibus_done = served[PEND_I];
        dbus_done = served[PEND_D];
        pend_nxt  = '0;
        state_nxt = ARB_IDLE;
      end
`ifdef MESM6_ARB_DMA_EN
      ARB_ACC_DMA: begin
        mem_read  = ~dma_we;
        mem_write = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        if (mem_done) begin
          dma_cap   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
`endif
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      pend       <= '0;
      served     <= '0;
      d_we       <= 1'b0;
      ibus_input <= '0;
      dbus_input <= '0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      served <= served_nxt;
      d_we   <= d_we_nxt;
      if (ibus_cap)
        ibus_input <= mem_rdata;
      if (dbus_cap)
        dbus_input <= mem_rdata;
    end
  end

`ifdef MESM6_ARB_DMA_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= dma_cap;
      if (dma_cap && !dma_we)
        dma_rdata <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// tb/tb_mesm6_mem_arbiter.sv - self-checking bench for mesm6_mem_arbiter
// Covers the DMA port as well when MESM6_ARB_DMA_EN is defined.
module tb_mesm6_mem_arbiter;
  import mesm6_arb_pkg::*;

  localparam bit DF = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read, dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output, dbus_input;
  logic        dbus_done;
  logic        mem_read, mem_write;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
`ifdef MESM6_ARB_DMA_EN
  logic        dma_req, dma_we, dma_ack;
  logic [14:0] dma_addr;
  logic [47:0] dma_wdata, dma_rdata;
`endif

  mesm6_mem_arbiter #(.DATA_FIRST(DF)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
`ifdef MESM6_ARB_DMA_EN
   ,.dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic        we;
    int          cyc;
  } acc_t;

  typedef struct {
    bit          f, r, w;
    logic [14:0] ia, da;
    logic [47:0] wd;
    int          ws;
    int          exp_cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic logic [47:0] init_val(input logic [14:0] a);
    if (a == 15'o100) return 48'h123456789ABC;
    return {a, 1'b0, ~a, 2'b01, a};
  endfunction

  // Memory responder: wait states, write commit, access log, protocol watch.
  logic [47:0] mem [logic [14:0]];
  acc_t        acc_q[$];
  int          mem_wait = 0;
  bit          spur_done = 1'b0;
  int          viol_cnt = 0;
  int          wcnt = 0;
  logic [14:0] hold_addr;
  logic [47:0] hold_wd;

  function automatic logic [47:0] mem_rd(input logic [14:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (mem_read && mem_write) viol_cnt++;
    if (mem_read || mem_write) begin
      if (wcnt > 0 && (mem_addr !== hold_addr || mem_wdata !== hold_wd)) viol_cnt++;
      hold_addr = mem_addr;
      hold_wd   = mem_wdata;
      if (wcnt >= mem_wait) begin
        mem_done = 1'b1;
        if (mem_write) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem_rd(mem_addr);
        acc_q.push_back(acc_t'{addr: mem_addr, we: mem_write, cyc: wcnt + 1});
        wcnt = 0;
      end else begin
        mem_done = 1'b0;
        wcnt++;
      end
    end else begin
      mem_done = spur_done;
      wcnt = 0;
    end
  end

  // Reference view of memory and of the two data registers.
  logic [47:0] ref_mem [logic [14:0]];
  logic [47:0] exp_ibus = '0;
  logic [47:0] exp_dbus = '0;

  function automatic logic [47:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drop_reqs();
    ibus_fetch = 1'b0;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
  endtask

  task automatic run_round(input string nm, input bit f, input bit r, input bit w,
                           input logic [14:0] ia, input logic [14:0] da, input logic [47:0] wd,
                           input int ws, input int exp_cyc);
    int s, v0, i_at, d_at, i_n, d_n;
    acc_t exp_acc[$];
    logic [47:0] fv;
    s = acc_q.size();
    v0 = viol_cnt;
    i_at = -1; d_at = -1; i_n = 0; d_n = 0;
    if (DF) begin
      if (r || w) exp_acc.push_back(acc_t'{addr: da, we: w, cyc: ws + 1});
      if (f) exp_acc.push_back(acc_t'{addr: ia, we: 1'b0, cyc: ws + 1});
    end else begin
      if (f) exp_acc.push_back(acc_t'{addr: ia, we: 1'b0, cyc: ws + 1});
      if (r || w) exp_acc.push_back(acc_t'{addr: da, we: w, cyc: ws + 1});
    end
    fv = (w && da == ia && DF) ? wd : ref_rd(ia);
    if (f) exp_ibus = fv;
    if (r) exp_dbus = ref_rd(da);
    if (w) ref_mem[da] = wd;
    mem_wait = ws;
    @(negedge clk);
    ibus_fetch = f; ibus_addr = ia;
    dbus_read = r; dbus_write = w; dbus_addr = da; dbus_output = wd;
    for (int k = 1; k <= exp_cyc + 2; k++) begin
      @(posedge clk); @(negedge clk);
      if (ibus_done) begin i_n++; if (i_at < 0) i_at = k; end
      if (dbus_done) begin d_n++; if (d_at < 0) d_at = k; end
      if (ibus_done || dbus_done) drop_reqs();
    end
    drop_reqs();
    if (f) chk({nm, " ibus_done cycle"}, i_at, exp_cyc);
    chk({nm, " ibus_done pulses"}, i_n, int'(f));
    if (r || w) chk({nm, " dbus_done cycle"}, d_at, exp_cyc);
    chk({nm, " dbus_done pulses"}, d_n, int'(r || w));
    chk({nm, " ibus_input"}, ibus_input, exp_ibus);
    chk({nm, " dbus_input"}, dbus_input, exp_dbus);
    chk({nm, " access count"}, acc_q.size() - s, exp_acc.size());
    foreach (exp_acc[j]) begin
      if (s + j < acc_q.size()) begin
        chk($sformatf("%s access%0d addr", nm, j), acc_q[s+j].addr, exp_acc[j].addr);
        chk($sformatf("%s access%0d we", nm, j), acc_q[s+j].we, exp_acc[j].we);
        chk($sformatf("%s access%0d strobe cycles", nm, j), acc_q[s+j].cyc, exp_acc[j].cyc);
      end
    end
    chk({nm, " strobe protocol violations"}, viol_cnt - v0, 0);
    if (w) chk({nm, " memory word"}, mem_rd(da), wd);
  endtask

  vec_t vecs[6];

  initial begin
    int s, n, d1, d2, i_at;
    reset = 1'b1;
    drop_reqs();
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0;
`ifdef MESM6_ARB_DMA_EN
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
`endif

    vecs[0] = vec_t'{f: 1, r: 0, w: 0, ia: 15'o100, da: 0,  wd: 0,               ws: 0, exp_cyc: 2};
    vecs[1] = vec_t'{f: 1, r: 1, w: 0, ia: 10,      da: 20, wd: 0,               ws: 0, exp_cyc: 3};
    vecs[2] = vec_t'{f: 0, r: 0, w: 1, ia: 0,       da: 5,  wd: 48'hFFFF00000001, ws: 3, exp_cyc: 5};
    vecs[3] = vec_t'{f: 0, r: 1, w: 0, ia: 0,       da: 21, wd: 0,               ws: 2, exp_cyc: 4};
    vecs[4] = vec_t'{f: 1, r: 0, w: 1, ia: 12,      da: 12, wd: 48'hA5A5_0F0F_3C3C, ws: 1, exp_cyc: 5};
    vecs[5] = vec_t'{f: 1, r: 1, w: 0, ia: 5,       da: 30, wd: 0,               ws: 2, exp_cyc: 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_read", mem_read, 0);
    chk("reset mem_write", mem_write, 0);
    chk("reset ibus_done", ibus_done, 0);
    chk("reset dbus_done", dbus_done, 0);
    chk("reset ibus_input", ibus_input, 0);
    chk("reset dbus_input", dbus_input, 0);
    reset = 1'b0;

    for (int j = 0; j < 6; j++)
      run_round($sformatf("vec%0d", j), vecs[j].f, vecs[j].r, vecs[j].w, vecs[j].ia,
                vecs[j].da, vecs[j].wd, vecs[j].ws, vecs[j].exp_cyc);

    // Fetch held across two microinstructions: two reads, done at cycles 2 and 5.
    mem_wait = 0;
    s = acc_q.size(); n = 0; d1 = -1; d2 = -1;
    exp_ibus = ref_rd(33);
    @(negedge clk);
    ibus_fetch = 1'b1; ibus_addr = 33;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (ibus_done) begin
        n++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 5) ibus_fetch = 1'b0;
    end
    chk("b2b first done cycle", d1, 2);
    chk("b2b second done cycle", d2, 5);
    chk("b2b done pulses", n, 2);
    chk("b2b memory reads", acc_q.size() - s, 2);
    chk("b2b ibus_input", ibus_input, exp_ibus);

    // mem_done with no strobe must not start or finish anything.
    @(negedge clk);
    spur_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("spurious done strobes", {mem_read, mem_write}, 2'b00);
      chk("spurious done pulses", {ibus_done, dbus_done}, 2'b00);
    end
    spur_done = 1'b0;

    for (int j = 0; j < 40; j++) begin
      bit f, r, w;
      int kind, ws, nacc;
      f = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      r = (kind == 1);
      w = (kind == 2);
      if (!f && kind == 0) f = 1'b1;
      ws = $urandom_range(0, 3);
      nacc = int'(f) + int'(r || w);
      run_round($sformatf("rand%0d", j), f, r, w, 15'($urandom_range(0, 15)),
                15'($urandom_range(0, 15)), {$urandom, 16'($urandom)}, ws, 1 + nacc * (1 + ws));
    end

`ifdef MESM6_ARB_DMA_EN
    begin
      int ack_at;
      mem_wait = 2; ack_at = -1; i_at = -1;
      exp_ibus = ref_rd(9);
      @(negedge clk);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); @(negedge clk);
        if (k == 1) begin ibus_fetch = 1'b1; ibus_addr = 9; end
        if (dma_ack && ack_at < 0) begin
          ack_at = k;
          dma_req = 1'b0;
          chk("dma rdata", dma_rdata, ref_rd(7));
        end
        if (ibus_done && i_at < 0) begin i_at = k; ibus_fetch = 1'b0; end
      end
      chk("dma ack cycle", ack_at, 4);
      chk("dma fetch done cycle", i_at, 8);
      chk("dma fetch ibus_input", ibus_input, exp_ibus);
      dma_req = 1'b0; ibus_fetch = 1'b0;
    end
`endif

    // Reset during ACC_I with memory stalled.
    mem_wait = 20;
    @(negedge clk);
    ibus_fetch = 1'b1; ibus_addr = 3;
    @(posedge clk); @(negedge clk);
    chk("rst_mid strobe before reset", mem_read, 1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid strobes after reset", {mem_read, mem_write}, 2'b00);
    chk("rst_mid done after reset", {ibus_done, dbus_done}, 2'b00);
    chk("rst_mid ibus_input cleared", ibus_input, 0);
    chk("rst_mid dbus_input cleared", dbus_input, 0);
    exp_ibus = ref_rd(3);
    exp_dbus = '0;
    reset = 1'b0;
    mem_wait = 0;
    i_at = -1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (ibus_done && i_at < 0) begin i_at = k; ibus_fetch = 1'b0; end
    end
    chk("rst_mid restart done cycle", i_at, 2);
    chk("rst_mid restart ibus_input", ibus_input, exp_ibus);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
